// File: rtl/dffsn_char_pkg.sv
// Shared encodings and LFSR helpers for the negative-edge set-flop characterizer.
package dffsn_char_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Four phases per vector: setup, capture edge, release, compare.
    localparam int PHASE_W = 2;

    // Fibonacci taps 8,6,5,4 expressed as a bit mask over value[7:0].
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // One LFSR step: shift left, feedback into bit 0.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

    // The all-zero state locks the LFSR, so a zero seed is promoted to 1.
    function automatic logic [7:0] seed_fix(input logic [7:0] s);
        return (s == 8'h00) ? 8'h01 : s;
    endfunction

    // Set is asserted (low) for one vector in four: when bits [2:1] are both zero.
    function automatic logic stim_sn(input logic [7:0] v);
        return (v[2:1] != 2'b00);
    endfunction

endpackage

// File: rtl/dffsn_char_seq_lfsr8.sv
// 8-bit Fibonacci LFSR with synchronous load of the (zero-protected) seed.
module lfsr8
    import dffsn_char_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rn,
    input  logic       load,
    input  logic       step,
    output logic [7:0] value
);

    localparam logic [7:0] SEED_EFF = seed_fix(SEED);

    // Reset and load both return to the seed; load wins over step.
    always_ff @(posedge clk) begin
        if (!rn)
            value <= SEED_EFF;
        else if (load)
            value <= SEED_EFF;
        else if (step)
            value <= lfsr_next(value);
    end

endmodule

// File: rtl/dffsn_char_seq.sv
// Stimulus/check sequencer for a negative-edge D flop with active-low set.
// Each vector is four cycles: drive D/SN, drop CLKN (capture), raise CLKN,
// then compare Q/QN against an internal reference flop.
module dffsn_char_seq
    import dffsn_char_pkg::*;
#(
    parameter int         N_VEC = 64,
    parameter logic [7:0] SEED  = 8'hA5
) (
    input  logic       CLK,
    input  logic       RN,
    input  logic       START,
    input  logic       DUT_Q,
    input  logic       DUT_QN,
    output logic       DUT_D,
    output logic       DUT_SN,
    output logic       DUT_CLKN,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [7:0] ERR_CNT
);

    localparam logic [7:0] SEED_EFF = seed_fix(SEED);
    localparam logic [9:0] LAST_VEC = 10'(N_VEC - 1);

    state_t               state, state_n;
    logic [PHASE_W-1:0]   phase, phase_n;
    logic [9:0]           vec_cnt, vec_n;
    logic [7:0]           err_n;
    logic                 model_q, model_n;
    logic                 d_n, sn_n, clkn_n;
    logic                 lfsr_load, lfsr_step;
    logic [7:0]           lfsr_val, lfsr_nxt;
    logic                 mismatch;

    lfsr8 #(.SEED(SEED)) u_lfsr (
        .clk   (CLK),
        .rn    (RN),
        .load  (lfsr_load),
        .step  (lfsr_step),
        .value (lfsr_val)
    );

    // Stimulus for the following vector is derived from the value the LFSR
    // is about to step to, so D/SN are ready in the same edge as the step.
    assign lfsr_nxt = lfsr_next(lfsr_val);
    assign mismatch = (DUT_Q != model_q) || (DUT_QN == model_q);

    // Next-state, datapath and stimulus decisions.
    always_comb begin
        state_n   = state;
        phase_n   = phase;
        vec_n     = vec_cnt;
        err_n     = ERR_CNT;
        model_n   = model_q;
        d_n       = DUT_D;
        sn_n      = DUT_SN;
        clkn_n    = DUT_CLKN;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                d_n    = 1'b0;
                sn_n   = 1'b1;
                clkn_n = 1'b1;
                if (START) begin
                    state_n   = ST_RUN;
                    phase_n   = '0;
                    vec_n     = '0;
                    err_n     = '0;
                    model_n   = 1'b1;
                    lfsr_load = 1'b1;
                    d_n       = SEED_EFF[0];
                    sn_n      = stim_sn(SEED_EFF);
                end
            end
            ST_RUN: begin
                phase_n = phase + 1'b1;
                case (phase)
                    2'd0: begin
                        // Falling CLKN lands here; the reference captures alongside.
                        clkn_n  = 1'b0;
                        model_n = DUT_SN ? DUT_D : 1'b1;
                    end
                    2'd1: clkn_n = 1'b1;
                    2'd2: clkn_n = 1'b1;
                    default: begin
                        if (mismatch && (ERR_CNT != 8'hFF))
                            err_n = ERR_CNT + 8'd1;
                        lfsr_step = 1'b1;
                        vec_n     = vec_cnt + 10'd1;
                        clkn_n    = 1'b1;
                        if (vec_cnt == LAST_VEC) begin
                            state_n = ST_DONE;
                            d_n     = 1'b0;
                            sn_n    = 1'b1;
                        end else begin
                            d_n  = lfsr_nxt[0];
                            sn_n = stim_sn(lfsr_nxt);
                        end
                    end
                endcase
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any run in the same edge.
    always_ff @(posedge CLK) begin
        if (!RN) begin
            state    <= ST_IDLE;
            phase    <= '0;
            vec_cnt  <= '0;
            ERR_CNT  <= '0;
            model_q  <= 1'b1;
            DUT_D    <= 1'b0;
            DUT_SN   <= 1'b1;
            DUT_CLKN <= 1'b1;
        end else begin
            state    <= state_n;
            phase    <= phase_n;
            vec_cnt  <= vec_n;
            ERR_CNT  <= err_n;
            model_q  <= model_n;
            DUT_D    <= d_n;
            DUT_SN   <= sn_n;
            DUT_CLKN <= clkn_n;
        end
    end

    assign BUSY = (state == ST_RUN);
    assign DONE = (state == ST_DONE);
    assign PASS = DONE && (ERR_CNT == 8'h00);

endmodule

// File: tb/tb_dffsn_char_seq.sv
// Directed bench: instance A (N_VEC=64, SEED=A5) and instance B (N_VEC=300, SEED=0),
// each driving a behavioural negative-edge set-flop with selectable faults.
module tb_dffsn_char_seq;

    localparam int NA = 64;
    localparam int NB = 300;

    logic       clk = 1'b0;
    logic       rn;
    logic       a_start, b_start;
    logic       a_q, a_qn, a_d, a_sn, a_clkn, a_busy, a_done, a_pass;
    logic       b_q, b_qn, b_d, b_sn, b_clkn, b_busy, b_done, b_pass;
    logic [7:0] a_err, b_err;
    logic       a_qi = 1'b1, b_qi = 1'b1;
    int         a_mode = 0, b_mode = 0;   // 0 ideal, 1 Q stuck at 0, 2 QN tied to Q
    int         n_chk = 0, n_err = 0;
    logic [1:0] seq_rec [0:NA-1];
    logic [1:0] seq_save[0:NA-1];

    always #5 clk = ~clk;

    dffsn_char_seq #(.N_VEC(NA), .SEED(8'hA5)) u_a (
        .CLK(clk), .RN(rn), .START(a_start), .DUT_Q(a_q), .DUT_QN(a_qn),
        .DUT_D(a_d), .DUT_SN(a_sn), .DUT_CLKN(a_clkn),
        .BUSY(a_busy), .DONE(a_done), .PASS(a_pass), .ERR_CNT(a_err)
    );

    dffsn_char_seq #(.N_VEC(NB), .SEED(8'h00)) u_b (
        .CLK(clk), .RN(rn), .START(b_start), .DUT_Q(b_q), .DUT_QN(b_qn),
        .DUT_D(b_d), .DUT_SN(b_sn), .DUT_CLKN(b_clkn),
        .BUSY(b_busy), .DONE(b_done), .PASS(b_pass), .ERR_CNT(b_err)
    );

    // Behavioural flops under test: capture on falling CLKN, async set on low SN.
    always @(negedge a_clkn or negedge a_sn)
        if (!a_sn) a_qi <= 1'b1; else a_qi <= a_d;
    always @(negedge b_clkn or negedge b_sn)
        if (!b_sn) b_qi <= 1'b1; else b_qi <= b_d;

    assign a_q  = (a_mode == 1) ? 1'b0 : a_qi;
    assign a_qn = (a_mode == 2) ? a_q  : ~a_qi;
    assign b_q  = (b_mode == 1) ? 1'b0 : b_qi;
    assign b_qn = (b_mode == 2) ? b_q  : ~b_qi;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] step8(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    task automatic chk_idle_a(input string tag);
        chk({tag, "_d"},    a_d,    1'b0);
        chk({tag, "_sn"},   a_sn,   1'b1);
        chk({tag, "_clkn"}, a_clkn, 1'b1);
        chk({tag, "_busy"}, a_busy, 1'b0);
    endtask

    // Runs instance A, checking every stimulus cycle against the LFSR model.
    // abort_at: cycle in which RN is pulled low (0 = none); pulse_at: cycle for a stray START.
    task automatic run_a(input int abort_at, input int pulse_at,
                         output int cycles, output int ones);
        logic [7:0] l;
        int c, ph, v;
        logic e;
        l = 8'hA5;
        ones = 0;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        c = 1;
        chk("start_err_clr", a_err,  8'h00);
        chk("start_done_lo", a_done, 1'b0);
        while (!a_done && c <= 4*NA + 8) begin
            ph = (c - 1) % 4;
            v  = (c - 1) / 4;
            chk("run_busy", a_busy, 1'b1);
            chk("run_d",    a_d,    l[0]);
            chk("run_sn",   a_sn,   (l[2:1] != 2'b00));
            chk("run_clkn", a_clkn, (ph != 1));
            if (ph == 0 && v < NA) begin
                seq_rec[v] = {a_d, a_sn};
                e = (l[2:1] == 2'b00) ? 1'b1 : l[0];
                if (e) ones++;
            end
            if (ph == 3) l = step8(l);
            if (c == abort_at) begin
                rn = 1'b0;
                tick();
                rn = 1'b1;
                chk_idle_a("abort");
                chk("abort_done", a_done, 1'b0);
                chk("abort_pass", a_pass, 1'b0);
                chk("abort_err",  a_err,  8'h00);
                cycles = c;
                return;
            end
            a_start = (c == pulse_at);
            tick();
            a_start = 1'b0;
            c++;
        end
        cycles = c;
    endtask

    initial begin
        int cyc, ones, c;
        rn = 1'b0; a_start = 1'b0; b_start = 1'b0;
        tick(); tick();
        chk_idle_a("rst");
        chk("rst_done", a_done, 1'b0);
        chk("rst_pass", a_pass, 1'b0);
        chk("rst_err",  a_err,  8'h00);
        chk("rst_b_busy", b_busy, 1'b0);
        chk("rst_b_sn",   b_sn,   1'b1);

        // START while in reset must not be remembered.
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        rn = 1'b1;
        tick();
        chk("start_in_rst", a_busy, 1'b0);

        // Ideal flop, stray START during vector 5.
        a_mode = 0;
        run_a(0, 21, cyc, ones);
        chk("ideal_latency", cyc, 4*NA + 1);
        chk("ideal_pass", a_pass, 1'b1);
        chk("ideal_err",  a_err,  8'h00);
        chk_idle_a("ideal_done");
        tick();
        chk("done_hold", a_done, 1'b1);

        // Q stuck at 0: one error per vector whose expected Q is 1.
        a_mode = 1;
        run_a(0, 0, cyc, ones);
        chk("stuck_latency", cyc, 4*NA + 1);
        chk("stuck_err",  a_err,  ones);
        chk("stuck_pass", a_pass, (ones == 0));

        // Reset during vector 10 phase 2, then an identical rerun.
        a_mode = 0;
        run_a(43, 0, cyc, ones);
        for (int i = 0; i <= 10; i++) seq_save[i] = seq_rec[i];
        tick();
        chk("post_abort_idle", a_done, 1'b0);
        run_a(0, 0, cyc, ones);
        chk("rerun_latency", cyc, 4*NA + 1);
        for (int i = 0; i <= 10; i++) chk("rerun_seq", seq_rec[i], seq_save[i]);

        // Instance B: zero seed, QN tied to Q, counter saturation.
        b_mode = 2;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        chk("b_first_d",    b_d,    1'b1);
        chk("b_first_sn",   b_sn,   1'b0);
        chk("b_first_clkn", b_clkn, 1'b1);
        c = 1;
        while (!b_done && c <= 4*NB + 8) begin
            tick();
            c++;
        end
        chk("b_latency", c, 4*NB + 1);
        chk("b_err_sat", b_err, 8'hFF);
        chk("b_pass",    b_pass, 1'b0);
        chk("b_busy",    b_busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/dffsn_char_seq.md
DFFSN_CHAR_SEQ -- requirements
Module: dffsn_char_seq

Interface
REQ-001 Parameter N_VEC, default 64, SHALL set the number of vectors per run; legal range 1..1023.
REQ-002 Parameter SEED, default 8'hA5, SHALL set the initial LFSR value; a zero seed SHALL be replaced by 8'h01.
REQ-003 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 RN  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 START  input  1  SHALL be the run request, sampled high in IDLE or DONE.
REQ-006 DUT_Q, DUT_QN  input  1 each  SHALL be the Q/QN outputs of the negative-edge set-flop under test.
REQ-007 DUT_D, DUT_SN, DUT_CLKN  output  1 each  SHALL be the registered stimulus driving the flop under test.
REQ-008 BUSY  output  1  SHALL be high while a run is in progress.
REQ-009 DONE  output  1  SHALL be high from run completion until the next accepted START or reset.
REQ-010 PASS  output  1  SHALL be valid only while DONE is high; high iff ERR_CNT==0.
REQ-011 ERR_CNT  output  8  SHALL be the mismatch count of the current or last run.

Function
REQ-012 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-013 IDLE->RUN and DONE->RUN SHALL occur on START high; entry SHALL clear ERR_CNT, load the LFSR with SEED, set the vector count to 0, set phase 0 and set BUSY high.
REQ-014 START in RUN SHALL be ignored.
REQ-015 Each vector SHALL take exactly 4 CLK cycles: phases 0,1,2,3.
REQ-016 Phase 0: DUT_D=LFSR[0]; DUT_SN=0 if LFSR[2:1]==2'b00, else 1; DUT_CLKN=1.
REQ-017 Phase 1: DUT_CLKN=0; this falling edge is the DUT capture edge. D and SN SHALL be held.
REQ-018 Phase 2: DUT_CLKN=1; D and SN SHALL be held.
REQ-019 Phase 3: compare DUT_Q against the expected value and DUT_QN against its inverse; any mismatch SHALL increment ERR_CNT by 1 (at most once per vector).
REQ-020 Reference model: expected Q SHALL be forced to 1 while SN=0; otherwise it SHALL take D at each phase-1 edge; the model SHALL be set to 1 at run start.
REQ-021 At the end of phase 3 the LFSR SHALL step (Fibonacci, taps 8,6,5,4) and the vector count SHALL increment.
REQ-022 After vector N_VEC-1 phase 3, the FSM SHALL go to DONE: BUSY=0, DONE=1, PASS=(ERR_CNT==0) including the final compare, DUT_CLKN=1, DUT_SN=1.
REQ-023 ERR_CNT SHALL saturate at 8'hFF.
REQ-024 In IDLE and DONE the stimulus SHALL be DUT_D=0, DUT_SN=1, DUT_CLKN=1.
REQ-025 Total run latency from the START-sampling edge to DONE high SHALL be 4*N_VEC+1 cycles.

Reset
REQ-026 With RN low at a CLK edge, the FSM SHALL be IDLE and the outputs SHALL be: DUT_D=0, DUT_SN=1, DUT_CLKN=1, BUSY=0, DONE=0, PASS=0, ERR_CNT=0; the LFSR SHALL be SEED.
REQ-027 A reset in RUN SHALL abort the run in the same edge, with no partial DONE.
REQ-028 START while RN is low SHALL be ignored.

Structure
REQ-029 The state encoding, the phase width and the LFSR tap constant SHALL live in package dffsn_char_pkg.
REQ-030 The LFSR SHALL be a sub-module lfsr8 (load, step, value).
REQ-031 No combinational path SHALL run from DUT_Q/DUT_QN to any output.

Verification
REQ-032 Ideal DUT model, N_VEC=64 -> DONE at cycle 257 after START, PASS=1, ERR_CNT=0.
REQ-033 DUT_Q stuck at 0 -> ERR_CNT equals the count of vectors with expected Q=1, PASS=0.
REQ-034 DUT_QN tied to DUT_Q, N_VEC=300 -> ERR_CNT saturates at 255, PASS=0.
REQ-035 RN low during vector 10 phase 2 -> next edge IDLE, all outputs at reset values; a new START reproduces the identical DUT_D/DUT_SN sequence.
REQ-036 SEED=0 -> first vector uses LFSR 8'h01 (DUT_D=1, DUT_SN=0); START pulsed mid-run -> no restart, DONE still at 4*N_VEC+1.
